// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner, imem requester and prefetch queue feeding decode.
// Define IFETCH_PERF_EN to build the stall/redirect performance counters.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              halt,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_redirect_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {IDLE, REQ} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [ADDR_W-1:0] pcs_q [DEPTH];
  logic [ADDR_W-1:0] pcs_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d, count_post;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic              push, pop;

  assign pop  = valid_q & instr_ready;
  assign push = (state_q == REQ) & imem_ack & ~redirect_valid;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    data_d     = data_q;
    pcs_d      = pcs_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_post = count_q + CNT_W'(push) - CNT_W'(pop);
    count_d    = count_post;
    if (push) begin
      data_d[wr_ptr_q] = imem_rdata;
      pcs_d[wr_ptr_q]  = fetch_pc_q;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    // Redirect wins over ack, pop and FSM progress in the same cycle.
    if (redirect_valid) begin
      state_d    = IDLE;
      fetch_pc_d = redirect_target;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: if (!halt && count_q < FULL) state_d = REQ;
        REQ: begin
          if (imem_ack) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
            if (halt || count_post == FULL) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    valid_d    = (count_d != '0);
    instr_d    = data_d[rd_ptr_d];
    instr_pc_d = pcs_d[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pcs_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      pcs_q      <= pcs_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

`ifdef IFETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] redir_cnt_q, redir_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (!valid_q && !halt && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (redirect_valid && redir_cnt_q != '1)
      redir_cnt_d = redir_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign perf_stall_cnt    = stall_cnt_q;
  assign perf_redirect_cnt = redir_cnt_q;
`else
  assign perf_stall_cnt    = '0;
  assign perf_redirect_cnt = '0;
`endif

endmodule
